// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data single-port memory arbiter.
// State and requester encodings are fixed so the control unit can decode them directly.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } state_e;

  typedef enum logic {
    PortFetch = 1'b0,
    PortData  = 1'b1
  } port_e;

  // Alternating priority on a tie: the port that did not win last time goes first.
  function automatic port_e arb_pick(input logic f_req, input logic d_req, input port_e last);
    port_e pick;
    if (f_req && d_req) begin
      pick = (last == PortData) ? PortFetch : PortData;
    end else if (f_req) begin
      pick = PortFetch;
    end else begin
      pick = PortData;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port RAM sequencer shared by the instruction-fetch and load/store paths.
// Grants one access at a time, counts RAM wait states and returns data with a one-cycle ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WR_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned MaxLat = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
  localparam logic [CntW-1:0] RdCnt = CntW'(RD_LAT - 1);
  localparam logic [CntW-1:0] WrCnt = CntW'(WR_LAT - 1);

  state_e            state_q, state_d;
  port_e             grant_q, grant_d;
  port_e             last_q, last_d;
  logic              we_q, we_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  port_e gnt_port;
  logic  gnt_store;

  always_comb begin
    gnt_port  = arb_pick(f_req, d_req, last_q);
    gnt_store = (gnt_port == PortData) && d_we;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    f_ack_d     = 1'b0;
    d_ack_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (f_req || d_req) begin
          grant_d     = gnt_port;
          last_d      = gnt_port;
          we_d        = gnt_store;
          mem_addr_d  = (gnt_port == PortFetch) ? f_addr : d_addr;
          mem_read_d  = !gnt_store;
          mem_write_d = gnt_store;
          cnt_d       = gnt_store ? WrCnt : RdCnt;
          if (gnt_store) begin
            mem_wdata_d = d_wdata;
          end
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          // Stores leave both read-data holding registers untouched.
          if (!we_q) begin
            if (grant_q == PortFetch) begin
              f_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = mem_rdata;
            end
          end
          f_ack_d = (grant_q == PortFetch);
          d_ack_d = (grant_q == PortData);
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= PortFetch;
      last_q      <= PortData;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      f_ack_q     <= f_ack_d;
      d_ack_q     <= d_ack_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: dut0 runs RD_LAT=1, dut1 runs RD_LAT=3; both WR_LAT=1.
// Stimulus pushes expected acks (port, data, cycle); a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  typedef struct {
    int          inst;
    bit          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sbq[$];
  int          rlen [2] = '{0, 0};
  int          wlen [2] = '{0, 0};

  logic        rst       [2];
  logic        f_req     [2];
  logic [8:0]  f_addr    [2];
  logic        f_ack     [2];
  logic [31:0] f_rdata   [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [8:0]  d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic        d_ack     [2];
  logic [31:0] d_rdata   [2];
  logic [8:0]  mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rd_lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] preload(input logic [8:0] a);
    case (a)
      9'h010:  return 32'h1234_5678;
      9'h011:  return 32'hA5A5_0011;
      9'h020:  return 32'h0000_2020;
      9'h030:  return 32'h3030_3030;
      default: return {23'h0, a} ^ 32'h5A00_0000;
    endcase
  endfunction

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1), .WR_LAT(1)) u_dut0 (
    .clock(clk), .reset(rst[0]),
    .f_req(f_req[0]), .f_addr(f_addr[0]), .f_ack(f_ack[0]), .f_rdata(f_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_read(mem_read[0]),
    .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3), .WR_LAT(1)) u_dut1 (
    .clock(clk), .reset(rst[1]),
    .f_req(f_req[1]), .f_addr(f_addr[1]), .f_ack(f_ack[1]), .f_rdata(f_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_read(mem_read[1]),
    .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // RAM model: read data presented only once mem_read has been up for RD_LAT-1 edges.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    logic [31:0] ram [512];
    bit          wr_vld [512];
    int          rd_age = 0;

    always @(posedge clk) begin
      if (mem_write[g]) begin
        ram[mem_addr[g]]    <= mem_wdata[g];
        wr_vld[mem_addr[g]] <= 1'b1;
      end
      rd_age <= mem_read[g] ? rd_age + 1 : 0;
    end

    assign mem_rdata[g] = (mem_read[g] && rd_age == rd_lat(g) - 1) ?
                          (wr_vld[mem_addr[g]] ? ram[mem_addr[g]] : preload(mem_addr[g])) :
                          32'hBAD0_BAD0;
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d): got %h, expected %h", nm, inst, act, exp);
    end
  endtask

  task automatic chk_reset(input int i);
    chk("rst_mem_addr", i, mem_addr[i], 0);
    chk("rst_mem_wdata", i, mem_wdata[i], 0);
    chk("rst_f_rdata", i, f_rdata[i], 0);
    chk("rst_d_rdata", i, d_rdata[i], 0);
    chk("rst_strobes", i, {mem_read[i], mem_write[i], f_ack[i], d_ack[i], busy[i]}, 0);
  endtask

  task automatic push(input int i, input bit port, input logic [31:0] data, input int c);
    exp_t e;
    e.inst = i;
    e.port = port;
    e.data = data;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  // One isolated access starting at the current negedge; port 0=fetch, 1=data.
  task automatic access(input int i, input bit port, input bit we, input logic [8:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data);
    int l;
    bit st;
    st = port && we;
    l  = st ? 1 : rd_lat(i);
    if (!port) begin
      f_req[i]  = 1'b1;
      f_addr[i] = addr;
    end else begin
      d_req[i]   = 1'b1;
      d_we[i]    = we;
      d_addr[i]  = addr;
      d_wdata[i] = wdata;
    end
    push(i, port, exp_data, cyc + 1 + l);
    for (int k = 0; k < l; k++) begin
      @(negedge clk);
      chk("mem_addr_hold", i, mem_addr[i], addr);
      chk("mem_read_lvl", i, mem_read[i], !st);
      chk("mem_write_lvl", i, mem_write[i], st);
      if (st) chk("mem_wdata", i, mem_wdata[i], wdata);
      f_addr[i]  = ~addr;
      d_addr[i]  = ~addr;
      d_wdata[i] = ~wdata;
    end
    @(negedge clk);
    chk("strobe_drop", i, {mem_read[i], mem_write[i]}, 0);
    f_req[i] = 1'b0;
    d_req[i] = 1'b0;
    @(negedge clk);
    chk("busy_idle", i, busy[i], 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        rlen[i] = 0;
        wlen[i] = 0;
      end else begin
        chk("mutex_rw", i, mem_read[i] & mem_write[i], 0);
        chk("mutex_ack", i, f_ack[i] & d_ack[i], 0);
        if (mem_read[i] || mem_write[i] || f_ack[i] || d_ack[i])
          chk("busy_active", i, busy[i], 1);
        if (f_ack[i] || d_ack[i]) begin
          if (sbq.size() == 0) begin
            chk("unexpected_ack", i, 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("ack_inst", i, i, e.inst);
            chk("ack_port", i, d_ack[i], e.port);
            chk("ack_cycle", i, cyc, e.cyc);
            chk("ack_rdata", i, e.port ? d_rdata[i] : f_rdata[i], e.data);
          end
        end
        if (mem_read[i]) rlen[i]++;
        else if (rlen[i] != 0) begin
          chk("rd_len", i, rlen[i], rd_lat(i));
          rlen[i] = 0;
        end
        if (mem_write[i]) wlen[i]++;
        else if (wlen[i] != 0) begin
          chk("wr_len", i, wlen[i], 1);
          wlen[i] = 0;
        end
      end
    end
  end

  initial begin
    int m;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; f_req[i] = 1'b0; f_addr[i] = '0; d_req[i] = 1'b0;
      d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // dut0: load, store, load-back, fetch
    access(0, 1'b1, 1'b0, 9'h011, 32'h0, 32'hA5A5_0011);
    access(0, 1'b1, 1'b1, 9'h0FF, 32'hDEAD_BEEF, 32'hA5A5_0011);
    chk("f_rdata_untouched", 0, f_rdata[0], 0);
    access(0, 1'b1, 1'b0, 9'h0FF, 32'h0, 32'hDEAD_BEEF);
    access(0, 1'b0, 1'b0, 9'h010, 32'h0, 32'h1234_5678);
    chk("d_rdata_after_fetch", 0, d_rdata[0], 32'hDEAD_BEEF);

    // Reset after a fetch win: tie must still go to fetch first
    rst[0] = 1'b1;
    #1 chk_reset(0);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    f_req[0] = 1'b1; f_addr[0] = 9'h010;
    d_req[0] = 1'b1; d_addr[0] = 9'h011; d_we[0] = 1'b0;
    for (int k = 0; k < 4; k++)
      push(0, k[0], k[0] ? 32'hA5A5_0011 : 32'h1234_5678, cyc + 2 + 3 * k);
    repeat (11) @(negedge clk);
    f_req[0] = 1'b0;
    d_req[0] = 1'b0;
    repeat (2) @(negedge clk);

    // dut1: RD_LAT=3 load with d_addr disturbed mid-access
    access(1, 1'b1, 1'b0, 9'h020, 32'h0, 32'h0000_2020);

    // Fetch abandoned by reset one cycle after grant
    f_req[1] = 1'b1; f_addr[1] = 9'h030;
    @(negedge clk);
    chk("abort_granted", 1, {mem_read[1], busy[1]}, 2'b11);
    @(negedge clk);
    rst[1] = 1'b1;
    #1 chk_reset(1);
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 9'h020;
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    m = cyc;
    push(1, 1'b0, 32'h3030_3030, m + 4);
    push(1, 1'b1, 32'h0000_2020, m + 9);
    repeat (4) @(negedge clk);
    f_req[1] = 1'b0;
    repeat (5) @(negedge clk);
    d_req[1] = 1'b0;
    repeat (3) @(negedge clk);

    chk("missing_acks", 0, sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
